lane_scroller: RTL and testbench
================================

Name: lane_scroller

Overview:
- Multi-lane horizontal scroll engine for the crossy-road playfield. Next generation of the single-lane horizontal scroller.
- Drives NUM_LANES independent horizontal offsets. Each lane has its own direction, step size and speed divider.
- Score-driven speed-up uses a clamped period rather than a counter-reload trick.
- Sits between the game-state logic (score, freeze) and the obstacle/row renderers, which consume h_pos and the per-lane move pulses.

Parameters:
- NUM_LANES, 4, number of independent scrolling lanes
- POS_W, 10, width of each lane position
- SCREEN_WIDTH, 640, wrap modulus; positions are always in 0..SCREEN_WIDTH-1
- CTR_W, 20, timing counter width; must hold BASE_PERIOD<<3
- BASE_PERIOD, 100000, tick period in clocks at score 0 (4 ms at 25 MHz)
- MIN_PERIOD, 4000, lower clamp on the effective period
- SCORE_W, 8, score width
- SPEEDUP_SHIFT, 8, period reduction per score point = 1<<SPEEDUP_SHIFT

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous, active-high
- score, in, SCORE_W, current score
- freeze, in, 1, holds all counters and positions (pause / game over)
- lane_dir, in, NUM_LANES, per lane: 1 = move right (increasing), 0 = move left
- lane_step, in, 3*NUM_LANES, per-lane pixels per tick, 0..7; lane i uses bits [3i+2:3i]
- lane_slow, in, 2*NUM_LANES, per-lane period multiplier exponent; lane period = eff_period << lane_slow[i]
- h_pos, out, POS_W*NUM_LANES, packed lane positions; lane i uses bits [POS_W*i+POS_W-1:POS_W*i]
- move_pulse, out, NUM_LANES, one-cycle pulse in the cycle after lane i's position updates

Behaviour:
- Reset: every h_pos lane = 0 (see optional feature), move_pulse = 0, all counters = 0.
- Effective period is combinational:
  - eff_period = BASE_PERIOD - (score << SPEEDUP_SHIFT), computed at CTR_W+1 bits.
  - If the result is < MIN_PERIOD or negative, eff_period = MIN_PERIOD.
- Per-lane counter:
  - lane_period[i] = eff_period << lane_slow[i].
  - Each clock, if not frozen: when ctr[i] >= lane_period[i]-1, it is a tick: ctr[i] <= 0. Otherwise ctr[i] <= ctr[i]+1.
  - The >= compare means a period that shrinks below the current count (score rises) ticks on the next cycle. No counter overrun.
- On a tick, lane_dir[i] and lane_step[i] are sampled that same cycle. Position update, modular:
  - Right: p+s >= SCREEN_WIDTH gives p+s-SCREEN_WIDTH, else p+s.
  - Left: p < s gives p+SCREEN_WIDTH-s, else p-s.
  - Arithmetic is at POS_W+1 bits.
- step = 0: tick still occurs and move_pulse still fires; position is unchanged.
- move_pulse[i] is registered: high for exactly one cycle, the cycle after the tick. At most one pulse per tick.
- freeze = 1:
  - Counters and positions hold, and move_pulse is forced to 0.
  - On release, counting resumes from the held value, with no catch-up ticks.
- Simultaneous ticks on several lanes are independent; every lane updates and pulses in the same cycle.
- Reset mid-operation overrides freeze and ticks.
- Lanes with equal configuration stay phase-locked.

Optional Feature:
- Macro LANE_PHASE_EN.
- Defined: reset loads lane i with h_pos = i*(SCREEN_WIDTH/NUM_LANES), integer division, so lanes start staggered. Counters also start staggered: ctr[i] = i*(BASE_PERIOD/NUM_LANES).
- Undefined: all positions and counters reset to 0.

Decomposition:
- Package scroll_pkg holds:
  - SCREEN_WIDTH and the BASE_PERIOD/MIN_PERIOD defaults
  - a function computing the clamped eff_period
  - a function doing the modular wrap step (pos, step, dir)
- One sub-module, lane_scroll_ch: a single lane's counter, tick compare, position register and pulse. It is instantiated NUM_LANES times via generate.
- eff_period is computed once in the top level and shared by all lanes.

Test Plan (bench uses BASE_PERIOD=10, MIN_PERIOD=4, SPEEDUP_SHIFT=1, SCREEN_WIDTH=16, NUM_LANES=2):
- Reset, score=0, lane0 dir=1 step=2 slow=0 -> first move_pulse[0] at cycle 11 after reset release; h_pos0 = 2, 4, 6 ... every 10 cycles.
- Lane0 at h_pos=14, dir=1, step=3 -> next value is 1 (wrap, not 0). Lane1 at h_pos=1, dir=0, step=3 -> next value is 14.
- score=2 -> period 6; score=200 -> period clamped to 4. Raise score from 0 to 4 with ctr=8 -> tick on the next cycle.
- lane1 slow=2, score=0 -> lane1 ticks every 40 cycles while lane0 ticks every 10. Coincident ticks both update in the same cycle.
- freeze asserted for 25 cycles mid-count -> no pulses and positions constant; after release the remaining count completes, with no burst of ticks.
- With LANE_PHASE_EN, reset -> h_pos0=0 and h_pos1=8.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared constants and arithmetic helpers for the multi-lane horizontal scroller.
package scroll_pkg;

  localparam int unsigned SCREEN_WIDTH_DEF = 640;
  localparam int unsigned BASE_PERIOD_DEF  = 100000;
  localparam int unsigned MIN_PERIOD_DEF   = 4000;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Score-reduced tick period, clamped at min_p. The 64-bit signed
  // intermediate means a large score can never wrap into a big period.
  function automatic int unsigned clamp_period(input int unsigned base,
                                               input int unsigned min_p,
                                               input int unsigned score,
                                               input int unsigned shift);
    longint signed diff;
    diff = longint'(base) - (longint'(score) << shift);
    if (diff < longint'(min_p))
      return min_p;
    return diff[31:0];
  endfunction

  // One modular move of pos by step in direction dir, kept in 0..width-1.
  function automatic int unsigned wrap_step(input int unsigned pos,
                                            input int unsigned step,
                                            input dir_t        dir,
                                            input int unsigned width);
    if (dir == DIR_RIGHT)
      return (pos + step >= width) ? pos + step - width : pos + step;
    return (pos < step) ? pos + width - step : pos - step;
  endfunction

endpackage

// File: rtl/lane_scroll_ch.sv
// One scroll lane: period counter with >= tick compare, wrapped position register
// and a registered move pulse in the cycle after each tick.
module lane_scroll_ch
  import scroll_pkg::*;
#(
  parameter int unsigned POS_W        = 10,
  parameter int unsigned CTR_W        = 20,
  parameter int unsigned SCREEN_WIDTH = SCREEN_WIDTH_DEF,
  parameter int unsigned RESET_POS    = 0,
  parameter int unsigned RESET_CTR    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic [CTR_W-1:0] eff_period,
  input  logic             dir,
  input  logic [2:0]       step,
  input  logic [1:0]       slow,
  output logic [POS_W-1:0] pos,
  output logic             pulse
);

  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] period;
  logic             tick;
  logic [POS_W-1:0] pos_next;

  // A period that drops below the current count ticks at once rather than overrunning.
  always_comb begin
    period   = eff_period << slow;
    tick     = (ctr >= period - CTR_W'(1));
    pos_next = POS_W'(wrap_step(32'(pos), 32'(step), dir_t'(dir), SCREEN_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr   <= CTR_W'(RESET_CTR);
      pos   <= POS_W'(RESET_POS);
      pulse <= 1'b0;
    end else if (freeze) begin
      pulse <= 1'b0;
    end else begin
      pulse <= tick;
      if (tick) begin
        ctr <= '0;
        pos <= pos_next;
      end else begin
        ctr <= ctr + CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/lane_scroller.sv
// Multi-lane horizontal scroll engine with score-driven clamped tick period.
// Optional LANE_PHASE_EN staggers lane start positions and counters at reset.
module lane_scroller
  import scroll_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned POS_W         = 10,
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int unsigned CTR_W         = 20,
  parameter int unsigned BASE_PERIOD   = BASE_PERIOD_DEF,
  parameter int unsigned MIN_PERIOD    = MIN_PERIOD_DEF,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned SPEEDUP_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SCORE_W-1:0]         score,
  input  logic                       freeze,
  input  logic [NUM_LANES-1:0]       lane_dir,
  input  logic [3*NUM_LANES-1:0]     lane_step,
  input  logic [2*NUM_LANES-1:0]     lane_slow,
  output logic [POS_W*NUM_LANES-1:0] h_pos,
  output logic [NUM_LANES-1:0]       move_pulse
);

  logic [CTR_W-1:0] eff_period;

  assign eff_period = CTR_W'(clamp_period(BASE_PERIOD, MIN_PERIOD, 32'(score), SPEEDUP_SHIFT));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
`ifdef LANE_PHASE_EN
    localparam int unsigned RST_POS = i * (SCREEN_WIDTH / NUM_LANES);
    localparam int unsigned RST_CTR = i * (BASE_PERIOD / NUM_LANES);
`else
    localparam int unsigned RST_POS = 0;
    localparam int unsigned RST_CTR = 0;
`endif

    lane_scroll_ch #(
      .POS_W       (POS_W),
      .CTR_W       (CTR_W),
      .SCREEN_WIDTH(SCREEN_WIDTH),
      .RESET_POS   (RST_POS),
      .RESET_CTR   (RST_CTR)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .freeze    (freeze),
      .eff_period(eff_period),
      .dir       (lane_dir[i]),
      .step      (lane_step[3*i +: 3]),
      .slow      (lane_slow[2*i +: 2]),
      .pos       (h_pos[POS_W*i +: POS_W]),
      .pulse     (move_pulse[i])
    );
  end

endmodule

// File: tb/tb_lane_scroller.sv
// Self-checking bench for lane_scroller: vector table, corner-case sequences
// and randomized traffic against a cycle-level reference model.
module tb_lane_scroller;

  localparam int NL   = 2;
  localparam int PW   = 10;
  localparam int SW   = 16;
  localparam int BASE = 10;
  localparam int MINP = 4;

  logic           clk;
  logic           reset;
  logic [7:0]     score;
  logic           freeze;
  logic [NL-1:0]  lane_dir;
  logic [3*NL-1:0] lane_step;
  logic [2*NL-1:0] lane_slow;
  logic [PW*NL-1:0] h_pos;
  logic [NL-1:0]  move_pulse;

  int total = 0;
  int bad   = 0;
  int nprint = 0;

  int unsigned m_pos[NL];
  int unsigned m_el[NL];
  bit          m_pulse[NL];

  lane_scroller #(
    .NUM_LANES    (NL),
    .POS_W        (PW),
    .SCREEN_WIDTH (SW),
    .CTR_W        (20),
    .BASE_PERIOD  (BASE),
    .MIN_PERIOD   (MINP),
    .SCORE_W      (8),
    .SPEEDUP_SHIFT(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .score     (score),
    .freeze    (freeze),
    .lane_dir  (lane_dir),
    .lane_step (lane_step),
    .lane_slow (lane_slow),
    .h_pos     (h_pos),
    .move_pulse(move_pulse)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference: count cycles since the last move; a lane moves once that count
  // reaches its (clamped, multiplied) period.
  task automatic model_step();
    int e;
    int unsigned per, s;
    for (int i = 0; i < NL; i++) begin
      if (reset) begin
`ifdef LANE_PHASE_EN
        m_pos[i] = i * (SW / NL);
        m_el[i]  = i * (BASE / NL);
`else
        m_pos[i] = 0;
        m_el[i]  = 0;
`endif
        m_pulse[i] = 0;
      end else if (freeze) begin
        m_pulse[i] = 0;
      end else begin
        e = BASE - int'(score) * 2;
        if (e < MINP) e = MINP;
        per = int'(e) * (1 << lane_slow[2*i +: 2]);
        if (m_el[i] + 1 >= per) begin
          m_pulse[i] = 1;
          m_el[i]    = 0;
          s = lane_step[3*i +: 3];
          if (lane_dir[i]) m_pos[i] = (m_pos[i] + s) % SW;
          else             m_pos[i] = (m_pos[i] + SW - s) % SW;
        end else begin
          m_pulse[i] = 0;
          m_el[i]    = m_el[i] + 1;
        end
      end
    end
  endtask

  task automatic tick_clk();
    logic [PW*NL-1:0] exp_h;
    logic [NL-1:0]    exp_p;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      exp_h[PW*i +: PW] = PW'(m_pos[i]);
      exp_p[i]          = m_pulse[i];
    end
    total++;
    if (h_pos !== exp_h || move_pulse !== exp_p) begin
      bad++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL model t=%0t h_pos=%h pulse=%b required h_pos=%h pulse=%b",
                 $time, h_pos, move_pulse, exp_h, exp_p);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    tick_clk();
    tick_clk();
    reset = 0;
  endtask

  task automatic wait_pulse(input int lane, input string name);
    int n;
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (!move_pulse[lane] && n < 200);
    if (!move_pulse[lane]) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=no_pulse required=pulse", name);
    end
  endtask

  typedef struct {
    logic [7:0] score;
    logic       dir;
    logic [2:0] step;
    logic [1:0] slow;
    int         exp_edges;
    int         exp_pos;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, c0, c1;
    vecs[0] = '{8'd0,   1'b1, 3'd2, 2'd0, 10, 2};
    vecs[1] = '{8'd2,   1'b1, 3'd2, 2'd0, 6,  2};
    vecs[2] = '{8'd200, 1'b1, 3'd2, 2'd0, 4,  2};
    vecs[3] = '{8'd0,   1'b0, 3'd3, 2'd0, 10, 13};
    vecs[4] = '{8'd0,   1'b1, 3'd0, 2'd0, 10, 0};
    vecs[5] = '{8'd0,   1'b1, 3'd5, 2'd2, 40, 5};
    vecs[6] = '{8'd200, 1'b0, 3'd7, 2'd3, 32, 9};

    reset = 1; freeze = 0; score = '0;
    lane_dir = '1; lane_step = '0; lane_slow = '0;

    do_reset();
    check("reset_pos0", int'(h_pos[PW-1:0]), 0);
`ifdef LANE_PHASE_EN
    check("reset_pos1", int'(h_pos[2*PW-1:PW]), 8);
`else
    check("reset_pos1", int'(h_pos[2*PW-1:PW]), 0);
`endif
    check("reset_pulse", int'(move_pulse), 0);

    // first-tick latency and first move per configuration
    for (int v = 0; v < 7; v++) begin
      score = vecs[v].score;
      lane_dir[0] = vecs[v].dir;
      lane_step[2:0] = vecs[v].step;
      lane_slow[1:0] = vecs[v].slow;
      do_reset();
      n = 0;
      do begin
        tick_clk();
        n++;
      end while (!move_pulse[0] && n < 300);
      check($sformatf("vec%0d_first_pulse_edge", v), n, vecs[v].exp_edges);
      check($sformatf("vec%0d_pos", v), int'(h_pos[PW-1:0]), vecs[v].exp_pos);
    end

    // wrap in both directions
    score = 0; lane_slow = '0;
    lane_dir = 2'b11; lane_step = {3'd1, 3'd2};
    do_reset();
    wait_pulse(0, "wrap_t1");
    lane_dir[1] = 1'b0; lane_step[5:3] = 3'd3;
    wait_pulse(0, "wrap_t2");
`ifndef LANE_PHASE_EN
    check("wrap_left", int'(h_pos[2*PW-1:PW]), 14);
`endif
    lane_step[5:3] = 3'd0;
    for (int k = 3; k <= 7; k++) wait_pulse(0, "wrap_tk");
    check("pos_before_wrap", int'(h_pos[PW-1:0]), 14);
    lane_step[2:0] = 3'd3;
    wait_pulse(0, "wrap_t8");
    check("wrap_right", int'(h_pos[PW-1:0]), 1);

    // score rises mid-count: shrunken period ticks on the next cycle
    score = 0; lane_dir = '1; lane_step = {3'd1, 3'd1}; lane_slow = '0;
    do_reset();
    c0 = 0;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      if (move_pulse[0]) c0++;
    end
    check("no_early_pulse", c0, 0);
    score = 4;
    tick_clk();
    check("score_raise_tick", int'(move_pulse[0]), 1);

    // slowed lane and coincident ticks
    score = 0; lane_slow = {2'd2, 2'd0};
    do_reset();
    c0 = 0; c1 = 0;
    for (int e = 1; e <= 85; e++) begin
      tick_clk();
      if (move_pulse[0]) c0++;
      if (move_pulse[1]) c1++;
`ifndef LANE_PHASE_EN
      if (e == 40) check("coincident_pulse", int'(move_pulse), 3);
`endif
    end
    check("lane0_pulse_count", c0, 8);
`ifndef LANE_PHASE_EN
    check("lane1_pulse_count", c1, 2);
`endif

    // freeze mid-count, then resume without catch-up
    lane_slow = '0;
    do_reset();
    for (int k = 0; k < 5; k++) tick_clk();
    freeze = 1;
    c0 = 0;
    for (int k = 0; k < 25; k++) begin
      tick_clk();
      if (move_pulse[0]) c0++;
    end
    check("freeze_pulses", c0, 0);
    check("freeze_pos", int'(h_pos[PW-1:0]), 0);
    freeze = 0;
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (!move_pulse[0] && n < 50);
    check("resume_edges", n, 5);
    c0 = 0;
    for (int k = 0; k < 9; k++) begin
      tick_clk();
      if (move_pulse[0]) c0++;
    end
    check("no_burst", c0, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 40 == 0)
        score = ($urandom % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      freeze    = ($urandom % 10 == 0);
      reset     = ($urandom % 500 == 0);
      lane_dir  = NL'($urandom);
      lane_step = (3*NL)'($urandom);
      if ($urandom % 100 == 0) lane_slow = (2*NL)'($urandom);
      tick_clk();
    end
    reset = 0; freeze = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

endmodule
